accum_bank: RTL
===============

Name: accum_bank

Overview:
- Parametrised multi-channel accumulator bank; successor to the single 16-bit free-running adder.
- Holds NUM_CH independent ACC_W-bit accumulators.
- Accepts one command per cycle (add, subtract, load, clear) aimed at one channel, with wrap or saturate arithmetic.
- Keeps a sticky overflow flag per channel, raises a threshold-crossing event, and provides a registered readback port. Sits between the input pins and the output mux of the top level.

Parameters:
- ACC_W, 16, accumulator width in bits (min IN_W+1, max 32).
- IN_W, 8, data_in width in bits.
- NUM_CH, 4, number of accumulator channels (1..8).
- CH_W, $clog2(NUM_CH) (min 1), width of channel-select fields; derived, not overridden.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ena  in  1  global enable; low = ignore in_valid, hold all state.
- in_valid  in  1  command strobe.
- op  in  2  command: 00 ADD, 01 SUB, 10 LOAD, 11 CLEAR.
- ch_sel  in  CH_W  target channel of command.
- data_in  in  IN_W  operand, unsigned, zero-extended to ACC_W.
- sat_en  in  1  1 = saturate, 0 = wrap (sampled with command).
- thr  in  ACC_W  threshold for crossing event.
- ovf_clr  in  NUM_CH  per-channel overflow-flag clear.
- rd_sel  in  CH_W  readback channel.
- rd_data  out  ACC_W  registered value of channel rd_sel.
- upd_valid  out  1  one-cycle pulse: a command was applied.
- upd_ch  out  CH_W  channel of applied command.
- upd_value  out  ACC_W  new value of that channel.
- thr_hit  out  1  one-cycle pulse with upd_valid when the channel crossed thr upward.
- ovf  out  NUM_CH  sticky overflow flags.

Behaviour:
- Reset (rst_n low, asynchronous): all accumulators, ovf, rd_data, upd_valid, upd_ch, upd_value and thr_hit are 0 immediately, without waiting for a clock edge. Release is synchronous to the next clk edge.
- Command accepted on a clk edge when ena=1, in_valid=1 and ch_sel<NUM_CH. If ch_sel>=NUM_CH the command is dropped: no state change and no upd_valid.
- Only the target channel changes. Latency is 1: the new value is visible in upd_value/rd_data on the cycle after the accepting edge.
- ADD: sum = acc + data_in computed at ACC_W+1 bits.
  - Carry out sets ovf[ch].
  - Wrap: acc = sum mod 2^ACC_W.
  - Saturate: acc = 2^ACC_W-1 on carry.
- SUB: acc - data_in.
  - Borrow sets ovf[ch].
  - Wrap: modular result.
  - Saturate: acc = 0 on borrow.
- LOAD: acc = zero-extended data_in; ovf unchanged.
- CLEAR: acc = 0 and ovf[ch] = 0.
- Overflow flag priority:
  - Set by the current command beats both ovf_clr[ch] and the CLEAR of the same channel. CLEAR cannot overflow, so this only arises with ovf_clr.
  - ovf_clr[i] clears flag i on any edge with ena=1, whether or not a command is present.
- thr_hit = 1 with upd_valid when old value < thr and new value >= thr (unsigned compare). LOAD and SUB can also cross. A wrap from max to a small value is not a crossing.
- upd_valid/thr_hit are low on every cycle after an edge with no accepted command. upd_ch and upd_value hold their last values.
- rd_data is a registered readback: rd_data <= acc[rd_sel] after the update on that edge. If rd_sel == ch_sel, the post-update value is returned. rd_sel>=NUM_CH returns 0. Readback keeps updating when ena=0.
- ena=0: accumulators, ovf and upd_* are frozen; upd_valid=0.

Decomposition:
- Package accum_pkg: op encoding constants OP_ADD/OP_SUB/OP_LOAD/OP_CLR and a 2-bit op typedef.
- Sub-module accum_alu: combinational, parametrised by ACC_W/IN_W.
  - Inputs: old value, operand, op, sat_en, thr.
  - Outputs: next value, overflow, crossing.
  - One instance shared, since only one channel updates per cycle.
- accum_bank holds the register array, flag logic and readback.

Test Plan (ACC_W=16, IN_W=8, NUM_CH=4):
- Assert rst_n=0 mid-stream between edges -> rd_data, ovf, upd_valid read 0 before the next edge; after release, all channels read 0x0000.
- ch0 ADD 0xFF ×257, sat_en=0 -> upd_value 0xFFFF after the 257th; then ADD 0x01 -> 0x0000 and ovf[0]=1.
- ch1 LOAD 0x05 then SUB 0x07:
  - sat_en=1 -> 0x0000, ovf[1]=1.
  - Repeat with sat_en=0 -> 0xFFFE, ovf[1]=1.
- thr=0x0100, ch2 ADD 0x80 ×3 -> values 0x0080, 0x0100, 0x0180; thr_hit only on the second update.
- ch0 overflowing ADD with ovf_clr[0]=1 on the same edge -> ovf[0]=1. Next edge ovf_clr[0]=1 alone -> ovf[0]=0. ch3 CLEAR -> value 0x0000, ovf[3]=0.
- ena=0 with in_valid=1, ch0 ADD 0x10 -> no upd_valid, ch0 unchanged. ch_sel=3 with rd_sel=3 and ADD 0x22 from 0 -> rd_data=0x0022 one cycle later.

Source files
------------

// File: rtl/accum_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module  : accum_pkg                                                      |
// | Purpose : Shared command encoding for the accumulator bank.              |
// |           op_t is the 2-bit command field; OP_* are its four values.     |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
package accum_pkg;

   typedef logic [1:0] op_t;

   localparam op_t OP_ADD  = 2'b00;
   localparam op_t OP_SUB  = 2'b01;
   localparam op_t OP_LOAD = 2'b10;
   localparam op_t OP_CLR  = 2'b11;

endpackage : accum_pkg
`default_nettype wire

// File: rtl/accum_alu.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module  : accum_alu                                                      |
// | Purpose : Combinational next-value datapath for one accumulator channel. |
// |           Shared by all channels since only one updates per cycle.       |
// | Ports   : old_i      current accumulator value                           |
// |           operand_i  unsigned operand, zero-extended to ACC_W            |
// |           op_i       command (ADD/SUB/LOAD/CLEAR)                        |
// |           sat_en_i   1 = saturate, 0 = wrap                              |
// |           thr_i      threshold for upward-crossing detection             |
// |           new_o      next accumulator value                              |
// |           ovf_o      carry (ADD) or borrow (SUB) occurred                |
// |           cross_o    old < thr and new >= thr (unsigned)                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
module accum_alu
   import accum_pkg::*;
#(
   parameter int ACC_W = 16,
   parameter int IN_W  = 8
) (
   input  logic [ACC_W-1:0] old_i,
   input  logic [IN_W-1:0]  operand_i,
   input  op_t              op_i,
   input  logic             sat_en_i,
   input  logic [ACC_W-1:0] thr_i,
   output logic [ACC_W-1:0] new_o,
   output logic             ovf_o,
   output logic             cross_o
);

   logic [ACC_W-1:0] opnd;
   logic [ACC_W:0]   sum;
   logic [ACC_W:0]   diff;

   assign opnd = ACC_W'(operand_i);

   // One extra bit exposes carry (sum) and borrow (diff) directly.
   assign sum  = {1'b0, old_i} + {1'b0, opnd};
   assign diff = {1'b0, old_i} - {1'b0, opnd};

   always_comb begin
      new_o = old_i;
      ovf_o = 1'b0;
      case (op_i)
         OP_ADD: begin
            ovf_o = sum[ACC_W];
            new_o = (sum[ACC_W] && sat_en_i) ? '1 : sum[ACC_W-1:0];
         end
         OP_SUB: begin
            ovf_o = diff[ACC_W];
            new_o = (diff[ACC_W] && sat_en_i) ? '0 : diff[ACC_W-1:0];
         end
         OP_LOAD: new_o = opnd;
         OP_CLR:  new_o = '0;
         default: new_o = old_i;
      endcase
   end

   // A wrap from near-max to a small value lands below thr and is not a crossing.
   assign cross_o = (old_i < thr_i) && (new_o >= thr_i);

endmodule : accum_alu
`default_nettype wire

// File: rtl/accum_bank.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module  : accum_bank                                                     |
// | Purpose : NUM_CH independent ACC_W-bit accumulators driven by one        |
// |           command per cycle, with sticky overflow flags, a threshold     |
// |           crossing pulse and a registered readback port.                 |
// | Ports   : clk, rst_n (async assert, active-low)                          |
// |           ena_i        global enable, low freezes state                  |
// |           in_valid_i   command strobe                                    |
// |           op_i         00 ADD, 01 SUB, 10 LOAD, 11 CLEAR                 |
// |           ch_sel_i     target channel                                    |
// |           data_in_i    unsigned operand                                  |
// |           sat_en_i     saturate (1) or wrap (0)                          |
// |           thr_i        crossing threshold                                |
// |           ovf_clr_i    per-channel overflow flag clear                   |
// |           rd_sel_i     readback channel                                  |
// |           rd_data_o    registered post-update value of rd_sel_i          |
// |           upd_valid_o  pulse: a command was applied                      |
// |           upd_ch_o     channel of last applied command                   |
// |           upd_value_o  new value of that channel                         |
// |           thr_hit_o    pulse with upd_valid_o on upward crossing         |
// |           ovf_o        sticky overflow flags                             |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
module accum_bank
   import accum_pkg::*;
#(
   parameter int   ACC_W  = 16,
   parameter int   IN_W   = 8,
   parameter int   NUM_CH = 4,
   localparam int  CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena_i,
   input  logic              in_valid_i,
   input  op_t               op_i,
   input  logic [CH_W-1:0]   ch_sel_i,
   input  logic [IN_W-1:0]   data_in_i,
   input  logic              sat_en_i,
   input  logic [ACC_W-1:0]  thr_i,
   input  logic [NUM_CH-1:0] ovf_clr_i,
   input  logic [CH_W-1:0]   rd_sel_i,
   output logic [ACC_W-1:0]  rd_data_o,
   output logic              upd_valid_o,
   output logic [CH_W-1:0]   upd_ch_o,
   output logic [ACC_W-1:0]  upd_value_o,
   output logic              thr_hit_o,
   output logic [NUM_CH-1:0] ovf_o
);

   logic [ACC_W-1:0]  acc_q [NUM_CH];
   logic [ACC_W-1:0]  acc_d [NUM_CH];
   logic [NUM_CH-1:0] ovf_q, ovf_d;
   logic [ACC_W-1:0]  rd_data_q, rd_data_d;
   logic              upd_valid_q;
   logic [CH_W-1:0]   upd_ch_q;
   logic [ACC_W-1:0]  upd_value_q;
   logic              thr_hit_q;

   logic              cmd_accept;
   logic [ACC_W-1:0]  alu_old, alu_new;
   logic              alu_ovf, alu_cross;

   // Extra bit lets the range check hold NUM_CH itself (e.g. 4 in 3 bits).
   assign cmd_accept = ena_i && in_valid_i &&
                       ({1'b0, ch_sel_i} < (CH_W+1)'(NUM_CH));

   always_comb begin
      alu_old = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_sel_i == CH_W'(i)) alu_old = acc_q[i];
      end
   end

   accum_alu #(
      .ACC_W (ACC_W),
      .IN_W  (IN_W)
   ) u_alu (
      .old_i     (alu_old),
      .operand_i (data_in_i),
      .op_i      (op_i),
      .sat_en_i  (sat_en_i),
      .thr_i     (thr_i),
      .new_o     (alu_new),
      .ovf_o     (alu_ovf),
      .cross_o   (alu_cross)
   );

   // Flag priority within a channel: ovf_clr, then CLEAR, then a new
   // overflow, so an overflow on the same edge always survives.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         acc_d[i] = acc_q[i];
         ovf_d[i] = ovf_q[i];
         if (ena_i) begin
            if (ovf_clr_i[i]) ovf_d[i] = 1'b0;
            if (cmd_accept && (ch_sel_i == CH_W'(i))) begin
               acc_d[i] = alu_new;
               if (op_i == OP_CLR) ovf_d[i] = 1'b0;
               if (alu_ovf)        ovf_d[i] = 1'b1;
            end
         end
      end
   end

   // Readback sees the post-update value, so it selects from acc_d.
   always_comb begin
      rd_data_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_sel_i == CH_W'(i)) rd_data_d = acc_d[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
         ovf_q       <= '0;
         rd_data_q   <= '0;
         upd_valid_q <= 1'b0;
         upd_ch_q    <= '0;
         upd_value_q <= '0;
         thr_hit_q   <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) acc_q[i] <= acc_d[i];
         ovf_q     <= ovf_d;
         rd_data_q <= rd_data_d;
         if (cmd_accept) begin
            upd_valid_q <= 1'b1;
            upd_ch_q    <= ch_sel_i;
            upd_value_q <= alu_new;
            thr_hit_q   <= alu_cross;
         end else begin
            upd_valid_q <= 1'b0;
            thr_hit_q   <= 1'b0;
         end
      end
   end

   assign rd_data_o   = rd_data_q;
   assign upd_valid_o = upd_valid_q;
   assign upd_ch_o    = upd_ch_q;
   assign upd_value_o = upd_value_q;
   assign thr_hit_o   = thr_hit_q;
   assign ovf_o       = ovf_q;

endmodule : accum_bank
`default_nettype wire
